koopa_sprite_fetch: RTL



---
 rtl/koopa_sprite_fetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/koopa_sprite_fetch.sv
// Sprite pixel fetch: screen pixel -> sheet ROM address -> colour/miss; KOOPA_SPRITE_FLIP_EN adds horizontal mirroring.
// Latency: fixed 3 cycles from pix_valid to out_valid (rom_addr registered after 1 cycle).
// Backpressure: none; one request per cycle accepted back-to-back.
module koopa_sprite_fetch #(
    parameter int          FRAME_W      = 23,
    parameter int          FRAME_H      = 30,
    parameter int          SHEET_W_LOG2 = 8,
    parameter int          ADDR_W       = 16,
    parameter logic [11:0] KEY_RGB      = 12'hF0F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [10:0]       anim_row,
    input  logic [10:0]       anim_col,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              facing_left,
    input  logic              pix_valid,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic              out_valid,
    output logic              out_hit,
    output logic [11:0]       out_rgb
);

    logic [10:0]       act_row;
    logic [10:0]       act_col;
    logic [9:0]        act_x;
    logic [9:0]        act_y;
    logic              act_left;

    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic [10:0]       dx_eff;
    logic              inbox;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] addr_d;

    logic              a_vld;
    logic              a_inbox;
    logic              b_vld;
    logic              b_inbox;
    logic              hit_c;

    // Shadow bank only moves at vblank so a frame is rendered from one consistent placement.
    always_ff @(posedge clk) begin
        if (!reset) begin
            act_row  <= '0;
            act_col  <= '0;
            act_x    <= '0;
            act_y    <= '0;
            act_left <= 1'b0;
        end else if (frame_start) begin
            act_row  <= anim_row;
            act_col  <= anim_col;
            act_x    <= sprite_x;
            act_y    <= sprite_y;
            act_left <= facing_left;
        end
    end

    always_comb begin
        x_end    = {1'b0, act_x} + 11'(FRAME_W);
        y_end    = {1'b0, act_y} + 11'(FRAME_H);
        inbox    = (pix_x >= act_x) && ({1'b0, pix_x} < x_end) &&
                   (pix_y >= act_y) && ({1'b0, pix_y} < y_end);
        dx       = {1'b0, pix_x - act_x};
        dy       = {1'b0, pix_y - act_y};
`ifdef KOOPA_SPRITE_FLIP_EN
        dx_eff   = act_left ? (11'(FRAME_W - 1) - dx) : dx;
`else
        dx_eff   = dx;
`endif
        row_base = ADDR_W'(act_row) + ADDR_W'(dy);
        addr_d   = '0;
        if (inbox) begin
            addr_d = (row_base << SHEET_W_LOG2) + ADDR_W'(act_col) + ADDR_W'(dx_eff);
        end
    end

`ifndef KOOPA_SPRITE_FLIP_EN
    logic unused_left;
    assign unused_left = act_left;
`endif

    assign hit_c = b_vld && b_inbox && (rom_data != KEY_RGB);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rom_addr  <= '0;
            a_vld     <= 1'b0;
            a_inbox   <= 1'b0;
            b_vld     <= 1'b0;
            b_inbox   <= 1'b0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_rgb   <= '0;
        end else begin
            rom_addr  <= pix_valid ? addr_d : '0;
            a_vld     <= pix_valid;
            a_inbox   <= pix_valid && inbox;
            // ROM answers for the stage-A address while the flags ride along.
            b_vld     <= a_vld;
            b_inbox   <= a_inbox;
            out_valid <= b_vld;
            out_hit   <= hit_c;
            out_rgb   <= hit_c ? rom_data : 12'h000;
        end
    end

endmodule
